riscv_muldiv_unit: RTL and testbench
====================================

# riscv_muldiv_unit

Iterative RV32M multiply/divide execution unit, one stage upstream of the writeback result-select mux; its `result` drives one data input of that mux. It accepts a multiply/divide instruction from decode and computes it over multiple cycles. While it computes it asserts `stall` to freeze the PC and the instruction, so the single-cycle core stays architecturally correct.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level from decode; high while the current instruction is an M-extension op.
- `op` input 3: funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data` input 32: operand A (multiplicand/dividend).
- `rs2_data` input 32: operand B (multiplier/divisor).
- `result` output 32: registered result, held until the next accepted op.
- `busy` output 1: registered; high in CALC and FIX.
- `done` output 1: registered; one-cycle pulse in state DONE.
- `stall` output 1: combinational, `start & ~done`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset state is IDLE.
- Reset values: `result`=0, `busy`=0, `done`=0, iteration counter=0.
- IDLE with `start`=1: latch `op` and operands.
  - Special case: go directly to DONE with the special result loaded.
  - Otherwise: load operand magnitudes, record sign flags, go to CALC.
- IDLE with `start`=0: stay in IDLE. Outputs hold.
- CALC runs 32 iterations using a 5-bit counter.
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit product.
  - Divide: restoring shift-subtract on magnitudes into a 32-bit quotient and 32-bit remainder.
  - After iteration 32, go to FIX.
- FIX: apply sign correction, write `result`, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
  - Product negated if the operand signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - DIV: quotient negated if the signs differ.
  - REM: remainder takes the sign of the dividend.
  - DIVU/REMU: unsigned, no correction.
- Special cases (divide ops only), resolved in one cycle:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- No exceptions or traps are raised.

## Timing
- Reference point: cycle S is the cycle in which `start` is sampled high in IDLE.
- Iterative op: CALC occupies cycles S+1..S+32, FIX is S+33, `done`=1 in S+34.
- Special case (or fast multiply, see Configuration): `done`=1 in S+1.
- `stall` is high from cycle S until the `done` cycle. It is low in the `done` cycle, so the PC advances on that edge and writeback captures `result`.
- `result` is valid from the `done` cycle onward and is stable until the next accepted op reaches DONE.
- Back-to-back M ops: after DONE the unit is in IDLE one cycle later. The next instruction's `start` is accepted there, giving a one-cycle gap minimum.
- `rst` in any state, including mid-CALC: on the next edge the FSM is in IDLE, `busy`=0, `done`=0, `result`=0, and the counter is cleared. Any partial result is discarded.
- Operand or `op` changes after acceptance are ignored; latched copies are used.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 33x33 signed multiply in IDLE.
  - The FSM goes IDLE→DONE and `done` is high in S+1.
  - Divide ops remain iterative.
- Undefined: all ops follow the 32-iteration path; no hardware multiplier is inferred.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `result`=0xFFFFFFEB. `done` in S+34 (S+1 with `MULDIV_FAST_MUL_EN`). `stall` high S..S+33.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - All with `done` in S+34.
- Division corner cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - Each with `done` in S+1.
- Reset mid-operation: assert `rst` at CALC iteration 10. Next cycle `busy`=0, `done`=0, `result`=0. A fresh DIVU 9/3 then yields 3 in S+34.
- Back-to-back and hold-off:
  - MUL 3×4 followed immediately by DIVU 12/4 → 12 then 3. The second `start` is accepted in the cycle after DONE.
  - Operands toggled mid-CALC do not change results.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide FSM.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply for MUL* ops.
module riscv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state;
  logic [4:0]            cnt;
  logic [2:0]            op_q;
  logic                  neg_q;
  logic [XLEN-1:0]       mcand;
  logic [2*XLEN-1:0]     prod;

  logic                  is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic                  div0, ovf, special;
  logic [XLEN-1:0]       spec_res;
  logic [XLEN:0]         add_sum, rem_sh, diff;
  logic [2*XLEN-1:0]     mul_next, div_next, prod_fix;
  logic [XLEN-1:0]       fix_res;

  function automatic logic [XLEN-1:0] cneg_w(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_dw(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign stall = start & ~done;

  // Decode at acceptance: signedness, magnitudes, result sign, one-cycle special cases
  always_comb begin
    is_div  = op[2];
    a_sgn   = is_div ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn   = is_div ? ~op[0] : ~op[1];
    a_neg   = a_sgn & rs1_data[XLEN-1];
    b_neg   = b_sgn & rs2_data[XLEN-1];
    a_mag   = cneg_w(a_neg, rs1_data);
    b_mag   = cneg_w(b_neg, rs2_data);
    res_neg = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
    div0    = is_div & (rs2_data == '0);
    ovf     = is_div & ~op[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);
    special = div0 | ovf;
    if (div0) spec_res = op[1] ? rs1_data : '1;
    else      spec_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fp;
  always_comb begin
    fa = a_sgn ? {{XLEN{rs1_data[XLEN-1]}}, rs1_data} : {{XLEN{1'b0}}, rs1_data};
    fb = b_sgn ? {{XLEN{rs2_data[XLEN-1]}}, rs2_data} : {{XLEN{1'b0}}, rs2_data};
    fp = fa * fb;
  end
`endif

  // One iteration: prod holds {acc, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    add_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mcand};
    mul_next = prod[0] ? {add_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
    rem_sh   = prod[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, mcand};
    div_next = diff[XLEN] ? {prod[2*XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
  end

  // Sign correction and result selection
  always_comb begin
    prod_fix = cneg_dw(neg_q, prod);
    if (op_q[2])
      fix_res = cneg_w(neg_q, op_q[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);
    else
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          neg_q <= res_neg;
          if (special) begin
            result <= spec_res;
            done   <= 1'b1;
            state  <= DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            result <= (op[1:0] == 2'b00) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
            done   <= 1'b1;
            state  <= DONE;
          end
`endif
          else begin
            mcand <= is_div ? b_mag : a_mag;
            prod  <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          prod <= op_q[2] ? div_next : mul_next;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit: directed RV32M cases plus random ops
// against an arithmetic reference model; honours MULDIV_FAST_MUL_EN for latency.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] result;
  logic        busy, done, stall;

  int n_cmp = 0;
  int n_err = 0;

  riscv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .result(result), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    longint unsigned up;
    int q;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = longint'(ua) * longint'(ub); return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = int'(signed'(a)) / int'(signed'(b));
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = int'(signed'(a)) % int'(signed'(b));
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 34;
  endfunction

  // Present an op at a negedge in IDLE, hold start until done, then let DONE pass.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit toggle, input string tag);
    int exp_lat, lat, stall_bad, busy_bad;
    bit seen;
    exp_lat = ref_latency(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b;
    #1;
    check({tag, "_stall_S"}, {31'b0, stall}, 32'd1);
    lat = 0; seen = 0; stall_bad = 0; busy_bad = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1;
      else begin
        if (stall !== 1'b1) stall_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (toggle && lat == 5) begin
          rs1_data = $urandom; rs2_data = $urandom; op = 3'($urandom_range(7));
        end
      end
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp);
    check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    check({tag, "_stall_busy_calc"}, stall_bad + busy_bad, 32'd0);
    @(posedge clk); #1;
    check({tag, "_idle_after_done"}, {30'b0, busy, done}, 32'd0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_busy_done", {30'b0, busy, done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_hold", {result[30:0], busy, done} , 33'd0);

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, "mul_7xm3");
    idle(3); #1;
    check("result_held", result, 32'hFFFFFFEB);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0, "mulh");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "mulhu");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "mulhsu");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0, "div_neg");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 0, "remu");
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 0, "rem_by0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, "rem_ovf");

    // Back-to-back: second op presented in the IDLE cycle right after DONE
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 0, "b2b_mul");
    run_op(3'd5, 32'd12, 32'd4, 32'd3, 0, "b2b_divu");

    // Operand/op changes during CALC are ignored
    run_op(3'd4, 32'hFFFF0000, 32'd7, ref_model(3'd4, 32'hFFFF0000, 32'd7), 1, "toggle_div");
    run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, ref_model(3'd1, 32'h12345678, 32'h9ABCDEF0), 1, "toggle_mulh");

    // Reset mid-CALC at iteration 10
    idle(1);
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midcalc_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_state", {30'b0, busy, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 0, "after_rst_divu");

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro  = 3'($urandom_range(7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(15);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel < 5) begin ra = $urandom_range(1000); rb = $urandom_range(1, 50); end
      run_op(ro, ra, rb, ref_model(ro, ra, rb), ($urandom_range(3) == 0), $sformatf("rnd%0d_op%0d", i, ro));
      if ($urandom_range(2) != 0) idle($urandom_range(1, 2));
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
